// File: rtl/reg_file_mp.sv
// Multi-port integer register file: two async read ports with optional write bypass,
// two prioritised write ports, hardwired-zero x0, busy scoreboard and a registered debug tap.
module reg_file_mp #(
  parameter  int XLEN   = 64,
  parameter  int NREGS  = 32,
  parameter  bit BYPASS = 1'b1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rd_addr1,
  output logic [XLEN-1:0] rd_data1,
  output logic            rd_busy1,
  input  logic [AW-1:0]   rd_addr2,
  output logic [XLEN-1:0] rd_data2,
  output logic            rd_busy2,
  input  logic            wr_enable0,
  input  logic [AW-1:0]   wr_addr0,
  input  logic [XLEN-1:0] wr_data0,
  input  logic            wr_enable1,
  input  logic [AW-1:0]   wr_addr1,
  input  logic [XLEN-1:0] wr_data1,
  input  logic            busy_set,
  input  logic [AW-1:0]   busy_addr,
  input  logic [AW-1:0]   debug_addr,
  output logic [XLEN-1:0] debug_output
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [XLEN-1:0] debug_q;

  logic wr0_commit, wr1_commit;
  assign wr0_commit = wr_enable0 && (wr_addr0 != '0);
  assign wr1_commit = wr_enable1 && (wr_addr1 != '0);

  // NOTE: every variable driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    // Port 1 is applied after port 0 so it wins a same-address conflict.
    if (wr0_commit) begin
      regs_d[wr_addr0] = wr_data0;
      busy_d[wr_addr0] = 1'b0;
    end
    if (wr1_commit) begin
      regs_d[wr_addr1] = wr_data1;
      busy_d[wr_addr1] = 1'b0;
    end
    // A newly issued producer supersedes a write retiring in the same cycle.
    if (busy_set && (busy_addr != '0)) begin
      busy_d[busy_addr] = 1'b1;
    end
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
  end

  // NOTE: the architectural state must read zero after reset, so this array is
  // built from resettable flops rather than an inferred RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q  <= '{default: '0};
      busy_q  <= '0;
      debug_q <= '0;
    end else begin
      regs_q  <= regs_d;
      busy_q  <= busy_d;
      debug_q <= regs_q[debug_addr];
    end
  end

  function automatic logic [XLEN-1:0] read_mux(input logic [AW-1:0] addr);
    logic [XLEN-1:0] data;
    data = regs_q[addr];
    if (addr == '0) begin
      data = '0;
    end else if (BYPASS && wr_enable1 && (wr_addr1 == addr)) begin
      data = wr_data1;
    end else if (BYPASS && wr_enable0 && (wr_addr0 == addr)) begin
      data = wr_data0;
    end
    return data;
  endfunction

  always_comb begin
    rd_data1 = read_mux(rd_addr1);
    rd_data2 = read_mux(rd_addr2);
    rd_busy1 = busy_q[rd_addr1];
    rd_busy2 = busy_q[rd_addr2];
  end

  assign debug_output = debug_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed and random checks of reg_file_mp against an array-based architectural model.
module tb_reg_file_mp;
  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [AW-1:0]   rd_addr1, rd_addr2, wr_addr0, wr_addr1, busy_addr, debug_addr;
  logic [XLEN-1:0] rd_data1, rd_data2, wr_data0, wr_data1, debug_output;
  logic            rd_busy1, rd_busy2, wr_enable0, wr_enable1, busy_set;

  reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst),
    .rd_addr1(rd_addr1), .rd_data1(rd_data1), .rd_busy1(rd_busy1),
    .rd_addr2(rd_addr2), .rd_data2(rd_data2), .rd_busy2(rd_busy2),
    .wr_enable0(wr_enable0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
    .wr_enable1(wr_enable1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
    .busy_set(busy_set), .busy_addr(busy_addr),
    .debug_addr(debug_addr), .debug_output(debug_output)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Architectural view: what each register holds, which are pending, last debug sample.
  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_busy [NREGS];
  logic [XLEN-1:0] m_dbg;

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] exp_read(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (wr_enable1 && wr_addr1 == a) return wr_data1;
    if (wr_enable0 && wr_addr0 == a) return wr_data0;
    return m_regs[a];
  endfunction

  task automatic check_reads(input string tag);
    #1;
    chk({tag, "_d1"}, rd_data1, exp_read(rd_addr1));
    chk({tag, "_d2"}, rd_data2, exp_read(rd_addr2));
    chk({tag, "_b1"}, {63'd0, rd_busy1}, {63'd0, (rd_addr1 != 0) && m_busy[rd_addr1]});
    chk({tag, "_b2"}, {63'd0, rd_busy2}, {63'd0, (rd_addr2 != 0) && m_busy[rd_addr2]});
  endtask

  task automatic tick(input string tag);
    logic [XLEN-1:0] nr [NREGS];
    bit              nb [NREGS];
    logic [XLEN-1:0] nd;
    nr = m_regs;
    nb = m_busy;
    nd = (debug_addr == 0) ? '0 : m_regs[debug_addr];
    if (rst) begin
      foreach (nr[i]) begin nr[i] = '0; nb[i] = 1'b0; end
      nd = '0;
    end else begin
      if (wr_enable0 && wr_addr0 != 0) begin nr[wr_addr0] = wr_data0; nb[wr_addr0] = 1'b0; end
      if (wr_enable1 && wr_addr1 != 0) begin nr[wr_addr1] = wr_data1; nb[wr_addr1] = 1'b0; end
      if (busy_set && busy_addr != 0) nb[busy_addr] = 1'b1;
    end
    @(posedge clk);
    #1;
    m_regs = nr;
    m_busy = nb;
    m_dbg  = nd;
    chk({tag, "_dbg"}, debug_output, m_dbg);
  endtask

  task automatic idle();
    wr_enable0 = 1'b0; wr_addr0 = '0; wr_data0 = '0;
    wr_enable1 = 1'b0; wr_addr1 = '0; wr_data1 = '0;
    busy_set   = 1'b0; busy_addr = '0;
  endtask

  initial begin
    foreach (m_regs[i]) begin m_regs[i] = '0; m_busy[i] = 1'b0; end
    m_dbg = '0;
    idle();
    rst = 1'b1; rd_addr1 = '0; rd_addr2 = 5'd1; debug_addr = '0;

    // Reset held two cycles, then x0/x1 read zero and not busy.
    tick("rst_a");
    tick("rst_b");
    rst = 1'b0;
    check_reads("t1");
    chk("t1_x0", rd_data1, 64'd0);
    chk("t1_x1", rd_data2, 64'd0);

    // Same-cycle bypass on port 0, then the stored value.
    wr_enable0 = 1'b1; wr_addr0 = 5'd5; wr_data0 = 64'h0123456789ABCDEF; rd_addr1 = 5'd5;
    check_reads("t2_byp");
    chk("t2_bypass", rd_data1, 64'h0123456789ABCDEF);
    tick("t2");
    idle();
    check_reads("t2_st");
    chk("t2_stored", rd_data1, 64'h0123456789ABCDEF);

    // Same-address conflict: port 1 wins.
    wr_enable0 = 1'b1; wr_addr0 = 5'd10; wr_data0 = 64'h1111111111111111;
    wr_enable1 = 1'b1; wr_addr1 = 5'd10; wr_data1 = 64'h2222222222222222;
    rd_addr2 = 5'd10;
    check_reads("t3_byp");
    tick("t3");
    idle();
    rd_addr1 = 5'd10;
    check_reads("t3_st");
    chk("t3_conflict", rd_data1, 64'h2222222222222222);

    // x0 ignores writes and busy_set.
    wr_enable1 = 1'b1; wr_addr1 = '0; wr_data1 = '1; rd_addr1 = '0;
    check_reads("t4_w");
    chk("t4_x0_byp", rd_data1, 64'd0);
    tick("t4_w");
    idle();
    busy_set = 1'b1; busy_addr = '0;
    tick("t4_b");
    idle();
    check_reads("t4_r");
    chk("t4_x0_busy", {63'd0, rd_busy1}, 64'd0);

    // Scoreboard set, clear by write, set-wins on collision.
    busy_set = 1'b1; busy_addr = 5'd7; rd_addr2 = 5'd7;
    tick("t5_set");
    idle();
    check_reads("t5_a");
    chk("t5_busy_set", {63'd0, rd_busy2}, 64'd1);
    wr_enable1 = 1'b1; wr_addr1 = 5'd7; wr_data1 = 64'h42;
    tick("t5_clr");
    idle();
    check_reads("t5_b");
    chk("t5_busy_clr", {63'd0, rd_busy2}, 64'd0);
    chk("t5_data", rd_data2, 64'h42);
    busy_set = 1'b1; busy_addr = 5'd7; wr_enable0 = 1'b1; wr_addr0 = 5'd7; wr_data0 = 64'h99;
    tick("t5_both");
    idle();
    check_reads("t5_c");
    chk("t5_set_wins", {63'd0, rd_busy2}, 64'd1);

    // Reset overrides a same-cycle write; debug tap reads zero.
    wr_enable0 = 1'b1; wr_addr0 = 5'd3; wr_data0 = 64'hABCD; rst = 1'b1; debug_addr = 5'd3;
    tick("t6_rst");
    rst = 1'b0;
    idle();
    rd_addr1 = 5'd3; rd_addr2 = 5'd7;
    check_reads("t6");
    chk("t6_x3", rd_data1, 64'd0);
    chk("t6_busy7", {63'd0, rd_busy2}, 64'd0);
    tick("t6_dbg");
    chk("t6_debug", debug_output, 64'd0);

    // Random traffic with a small address pool so conflicts and bypasses are frequent.
    for (int cyc = 0; cyc < 400; cyc++) begin
      rst        = ($urandom_range(0, 99) == 0);
      wr_enable0 = $urandom_range(0, 1) == 1;
      wr_enable1 = $urandom_range(0, 2) == 0;
      busy_set   = $urandom_range(0, 2) == 0;
      wr_addr0   = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      wr_addr1   = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      busy_addr  = AW'($urandom_range(0, 7));
      rd_addr1   = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      rd_addr2   = AW'($urandom_range(0, 7));
      debug_addr = AW'($urandom_range(0, 7));
      wr_data0   = {$urandom, $urandom};
      wr_data1   = {$urandom, $urandom};
      check_reads("rnd");
      tick("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
